// File: rtl/uart_pkg.sv
// Shared types for the UART frame timing blocks: frame phases and stop-bit modes.
package uart_pkg;

    localparam int DATA_MAX_DEFAULT = 9;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_START  = 3'd1,
        PH_DATA   = 3'd2,
        PH_PARITY = 3'd3,
        PH_STOP   = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        STOP_1    = 2'b00,
        STOP_1P5  = 2'b01,
        STOP_2    = 2'b10,
        STOP_RSVD = 2'b11
    } stop_mode_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Modulo-OVS oversample tick counter with bit-centre and last-tick decodes.
module uart_bit_timer #(
    parameter int OVS = 16,
    localparam int TW = $clog2(OVS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          clr,
    output logic [TW-1:0] tick,
    output logic          mid,
    output logic          last
);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    always_comb begin
        tick_d = tick_q;
        if (clr || !run) begin
            tick_d = '0;
        end else if (tick_q == TW'(OVS - 1)) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
    assign mid  = run && (tick_q == TW'(OVS / 2));
    assign last = run && (tick_q == TW'(OVS - 1));

endmodule

// File: rtl/uart_frame_timer.sv
// UART frame sequencer: walks START/DATA/PARITY/STOP bit periods on an oversampled clock.
module uart_frame_timer
    import uart_pkg::*;
#(
    parameter int OVS      = 16,
    parameter int DATA_MAX = DATA_MAX_DEFAULT
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic [1:0] cfg_stop_mode,
    output phase_e     phase,
    output logic [3:0] bit_idx,
    output logic       mid_tick,
    output logic       bit_end,
    output logic       frame_done,
    output logic       busy
);

    localparam int TW  = $clog2(OVS);
    localparam int SCW = $clog2(2 * OVS);

    if (OVS < 4 || (OVS % 2) != 0) begin : g_ovs_check
        $error("uart_frame_timer: OVS must be even and >= 4");
    end

    phase_e           phase_q, phase_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [SCW-1:0]   stop_cnt_q, stop_cnt_d;
    logic [3:0]       data_bits_q, data_bits_d;
    logic             parity_q, parity_d;
    stop_mode_e       stop_mode_q, stop_mode_d;

    logic             latch;
    logic             run;
    logic             frame_end;
    logic             tmr_clr;
    logic [TW-1:0]    tick;
    logic             tmr_mid;
    logic             tmr_last;

    function automatic logic [3:0] clamp_bits(input logic [3:0] b);
        if (b < 4'd5) return 4'd5;
        if (b > 4'(DATA_MAX)) return 4'(DATA_MAX);
        return b;
    endfunction

    // Index of the final STOP tick for each supported stop length.
    function automatic logic [SCW-1:0] stop_last(input stop_mode_e m);
        case (m)
            STOP_1P5: return SCW'(OVS + OVS / 2 - 1);
            STOP_2:   return SCW'(2 * OVS - 1);
            default:  return SCW'(OVS - 1);
        endcase
    endfunction

    assign run       = (phase_q != PH_IDLE);
    assign frame_end = (phase_q == PH_STOP) && (stop_cnt_q == stop_last(stop_mode_q));
    assign tmr_clr   = abort || frame_end;

    uart_bit_timer #(.OVS(OVS)) u_bit_timer (
        .clk  (baud_clk),
        .rst  (rst),
        .run  (run),
        .clr  (tmr_clr),
        .tick (tick),
        .mid  (tmr_mid),
        .last (tmr_last)
    );

    always_comb begin
        phase_d     = phase_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        data_bits_d = data_bits_q;
        parity_d    = parity_q;
        stop_mode_d = stop_mode_q;
        latch       = 1'b0;

        case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    phase_d = PH_START;
                    latch   = 1'b1;
                end
            end
            PH_START: begin
                if (tmr_last) phase_d = PH_DATA;
            end
            PH_DATA: begin
                if (tmr_last) begin
                    if (bit_idx_q == data_bits_q - 4'd1) begin
                        bit_idx_d = '0;
                        phase_d   = parity_q ? PH_PARITY : PH_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            PH_PARITY: begin
                if (tmr_last) phase_d = PH_STOP;
            end
            PH_STOP: begin
                if (frame_end) begin
                    stop_cnt_d = '0;
                    if (start) begin
                        phase_d = PH_START;
                        latch   = 1'b1;
                    end else begin
                        phase_d = PH_IDLE;
                    end
                end else begin
                    stop_cnt_d = stop_cnt_q + SCW'(1);
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        if (abort) begin
            phase_d    = PH_IDLE;
            bit_idx_d  = '0;
            stop_cnt_d = '0;
            latch      = 1'b0;
        end

        // The reserved stop encoding is folded into single-stop at capture time.
        if (latch) begin
            data_bits_d = clamp_bits(cfg_data_bits);
            parity_d    = cfg_parity_en;
            stop_mode_d = (stop_mode_e'(cfg_stop_mode) == STOP_RSVD) ? STOP_1
                                                                    : stop_mode_e'(cfg_stop_mode);
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            phase_q    <= PH_IDLE;
            bit_idx_q  <= '0;
            stop_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    always_ff @(posedge baud_clk) begin
        data_bits_q <= data_bits_d;
        parity_q    <= parity_d;
        stop_mode_q <= stop_mode_d;
    end

    assign phase      = phase_q;
    assign bit_idx    = bit_idx_q;
    assign mid_tick   = tmr_mid;
    assign bit_end    = tmr_last || frame_end;
    assign frame_done = frame_end;
    assign busy       = run;

endmodule

// File: tb/tb_uart_frame_timer.sv
// Self-checking bench for uart_frame_timer: table-driven frames, corner sequences and random frames vs. an arithmetic model.
module tb_uart_frame_timer;
    import uart_pkg::*;

    localparam int OVS  = 16;
    localparam int DMAX = 9;

    logic       baud_clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic [1:0] cfg_stop_mode;
    phase_e     phase;
    logic [3:0] bit_idx;
    logic       mid_tick;
    logic       bit_end;
    logic       frame_done;
    logic       busy;
    logic [10:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int bits;
        int par;
        int mode;
        int exp_len;
    } vec_t;

    vec_t tbl[10];

    uart_frame_timer #(.OVS(OVS), .DATA_MAX(DMAX)) dut (
        .baud_clk      (baud_clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_stop_mode (cfg_stop_mode),
        .phase         (phase),
        .bit_idx       (bit_idx),
        .mid_tick      (mid_tick),
        .bit_end       (bit_end),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 baud_clk = ~baud_clk;

    assign obs = {phase, bit_idx, mid_tick, bit_end, frame_done, busy};

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%0h expected=%0h", name, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    function automatic int eff_bits(input int b);
        return (b < 5) ? 5 : ((b > DMAX) ? DMAX : b);
    endfunction

    function automatic int stop_ticks(input int m);
        return (m == 1) ? OVS + OVS / 2 : ((m == 2) ? 2 * OVS : OVS);
    endfunction

    function automatic int frame_len(input int b, input int p, input int m);
        return OVS * (1 + eff_bits(b) + p) + stop_ticks(m);
    endfunction

    // Expected outputs k cycles after START entry: every bit period starts on a multiple of OVS.
    function automatic logic [10:0] model_vec(input int k, input int n, input int p, input int len);
        phase_e ph;
        int     idx;
        logic   m, e, d;
        idx = 0;
        if (k < OVS) ph = PH_START;
        else if (k < OVS * (1 + n)) begin
            ph  = PH_DATA;
            idx = (k - OVS) / OVS;
        end else if (k < OVS * (1 + n + p)) ph = PH_PARITY;
        else ph = PH_STOP;
        m = ((k % OVS) == OVS / 2);
        d = (k == len - 1);
        e = ((k % OVS) == OVS - 1) || d;
        return {ph, 4'(idx), m, e, d, 1'b1};
    endfunction

    task automatic idle_tick(input string name);
        start = 1'b0;
        abort = 1'b0;
        tick();
        check(name, 0, 32'(obs), 32'd0);
    endtask

    // sc: 0 = cfg steady, 1 = cfg/start randomised mid-frame, 2 = data bits dropped to 5 at DATA bit 3
    task automatic run_frame(input int b, input int p, input int m, input int sc, input int hold,
                             input int abort_at, input int rst_at, output int len);
        int n;
        int lm;
        n   = eff_bits(b);
        lm  = frame_len(b, p, m);
        len = -1;
        cfg_data_bits = 4'(b);
        cfg_parity_en = p[0];
        cfg_stop_mode = 2'(m);
        start = 1'b1;
        abort = 1'b0;
        tick();
        for (int k = 0; k < lm + OVS; k++) begin
            check("trace", k, 32'(obs), 32'(model_vec(k, n, p, lm)));
            if (frame_done) begin
                len = k + 1;
                return;
            end
            if (k == abort_at) begin
                abort = 1'b1;
                start = 1'($urandom_range(0, 1));
                tick();
                abort = 1'b0;
                start = 1'b0;
                check("abort_idle", k, 32'(obs), 32'd0);
                len = 0;
                return;
            end
            if (k == rst_at) begin
                rst   = 1'b1;
                start = 1'b1;
                abort = 1'b1;
                repeat (3) begin
                    tick();
                    check("rst_hold", k, 32'(obs), 32'd0);
                end
                rst   = 1'b0;
                start = 1'b0;
                abort = 1'b0;
                len   = 0;
                return;
            end
            start = (hold != 0) ? 1'b1 : ((sc == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (sc == 1) begin
                cfg_data_bits = 4'($urandom);
                cfg_parity_en = 1'($urandom);
                cfg_stop_mode = 2'($urandom);
            end else if (sc == 2 && k == OVS * 4) begin
                cfg_data_bits = 4'd5;
            end
            tick();
        end
        check("frame_done_seen", lm, 32'(frame_done), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int any_done;
        int any_busy;

        tbl[0] = '{8, 0, 0, 160};
        tbl[1] = '{8, 1, 1, 184};
        tbl[2] = '{5, 0, 2, 128};
        tbl[3] = '{9, 1, 2, 208};
        tbl[4] = '{12, 0, 3, 176};
        tbl[5] = '{3, 0, 0, 112};
        tbl[6] = '{7, 1, 3, 160};
        tbl[7] = '{0, 1, 1, 136};
        tbl[8] = '{15, 1, 1, 200};
        tbl[9] = '{6, 0, 1, 136};

        rst = 1'b1; start = 1'b1; abort = 1'b1;
        cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop_mode = 2'b00;
        repeat (3) begin
            tick();
            check("reset", 0, 32'(obs), 32'd0);
        end
        rst = 1'b0;
        idle_tick("idle_after_reset");

        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i].bits, tbl[i].par, tbl[i].mode, 0, 0, -1, -1, len);
            check("table_len", i, 32'(len), 32'(tbl[i].exp_len));
            idle_tick("table_idle");
        end

        // Back-to-back frames with start held: second START must follow frame_done directly.
        run_frame(5, 0, 2, 0, 1, -1, -1, len);
        check("b2b_len_first", 0, 32'(len), 32'd128);
        run_frame(9, 1, 2, 0, 1, -1, -1, len);
        check("b2b_len_second", 0, 32'(len), 32'd208);
        idle_tick("b2b_idle");

        run_frame(8, 0, 0, 2, 0, -1, -1, len);
        check("cfg_change_len", 0, 32'(len), 32'd160);
        idle_tick("cfg_change_idle");

        run_frame(8, 0, 0, 0, 0, OVS + 4 * OVS + 7, -1, len);
        any_done = 0;
        any_busy = 0;
        start = 1'b0;
        repeat (200) begin
            tick();
            if (frame_done) any_done++;
            if (busy) any_busy++;
        end
        check("abort_no_done", 0, 32'(any_done), 32'd0);
        check("abort_stays_idle", 0, 32'(any_busy), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        check("abort_over_start", 0, 32'(obs), 32'd0);
        idle_tick("abort_release_idle");

        run_frame(8, 1, 1, 0, 0, -1, 170, len);
        run_frame(12, 0, 3, 0, 0, -1, -1, len);
        check("post_rst_len", 0, 32'(len), 32'd176);
        idle_tick("post_rst_idle");

        for (int i = 0; i < 30; i++) begin
            int b, p, m, hold, ab, lm, gap;
            b    = int'($urandom_range(0, 15));
            p    = int'($urandom_range(0, 1));
            m    = int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 1));
            lm   = frame_len(b, p, m);
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lm - 2)) : -1;
            run_frame(b, p, m, 1, hold, ab, -1, len);
            if (ab < 0) check("rand_len", i, 32'(len), 32'(lm));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_tick("rand_gap_idle");
        end
        idle_tick("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_timer.md
UART_FRAME_TIMER -- requirements
Module: uart_frame_timer

Interface
REQ-001 Parameter OVS, default 16, oversampling ticks per bit; SHALL be even and >= 4.
REQ-002 Parameter DATA_MAX, default 9, maximum data bits per frame.
REQ-003 baud_clk  input  1  single clock, one oversample tick per rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  frame start request, level-sampled.
REQ-006 abort  input  1  synchronous frame abort.
REQ-007 cfg_data_bits  input  4  data bits per frame, legal range 5..DATA_MAX.
REQ-008 cfg_parity_en  input  1  insert one parity bit period.
REQ-009 cfg_stop_mode  input  2  00 = 1 stop bit, 01 = 1.5 stop bits, 10 = 2 stop bits, 11 = reserved.
REQ-010 phase  output  3  current phase_e: IDLE, START, DATA, PARITY, STOP.
REQ-011 bit_idx  output  4  data bit index within DATA; 0 elsewhere.
REQ-012 mid_tick  output  1  one-cycle pulse at the bit centre (sample point).
REQ-013 bit_end  output  1  one-cycle pulse on the last tick of each bit period.
REQ-014 frame_done  output  1  one-cycle pulse on the last tick of STOP.
REQ-015 busy  output  1  high whenever phase != IDLE.

Function
REQ-016 In IDLE with start=1, the block SHALL enter START on the next cycle with tick counter 0 and SHALL latch all cfg_* inputs.
REQ-017 Changes to cfg_* after the latch SHALL have no effect until the next accepted start.
REQ-018 The tick counter SHALL increment every cycle outside IDLE, wrap from OVS-1 to 0, and be held at 0 in IDLE.
REQ-019 mid_tick SHALL assert when tick counter == OVS/2 in START, DATA and PARITY, and in every whole stop bit.
REQ-020 bit_end SHALL assert when tick counter == OVS-1.
REQ-021 START SHALL last exactly one bit period, then transition to DATA with bit_idx=0.
REQ-022 In DATA, bit_idx SHALL increment on each bit_end; on bit_end with bit_idx == data_bits-1, the block SHALL go to PARITY if parity is enabled, else to STOP.
REQ-023 PARITY SHALL last one bit period, then go to STOP.
REQ-024 STOP duration SHALL be OVS ticks for mode 00, OVS+OVS/2 for mode 01, and 2*OVS for mode 10; a stop counter of width $clog2(2*OVS) SHALL time it.
REQ-025 For 1.5 stop bits, bit_end SHALL pulse at the end of the first whole stop bit and no mid_tick SHALL occur in the half bit.
REQ-026 frame_done and bit_end SHALL coincide on the final STOP tick.
REQ-027 Frame length in cycles SHALL equal OVS*(1 + data_bits + parity) + stop_ticks.
REQ-028 Boundary case: start=1 in the frame_done cycle SHALL go directly to START, with no IDLE cycle, and re-latch cfg.
REQ-029 Boundary case: a latched cfg_data_bits < 5 SHALL clamp to 5, and > DATA_MAX SHALL clamp to DATA_MAX.
REQ-030 Boundary case: cfg_stop_mode 11 SHALL behave as 00.
REQ-031 Boundary case: abort=1 in any phase SHALL force IDLE next cycle with all counters 0, and SHALL suppress frame_done.
REQ-032 Boundary case: abort SHALL take priority over start in the same cycle.
REQ-033 All outputs SHALL be registered or decoded only from registered state, with no combinational path from inputs to outputs.

Reset
REQ-034 While rst=1 the block SHALL hold phase=IDLE, bit_idx=0, tick and stop counters at 0, and mid_tick, bit_end, frame_done and busy at 0.
REQ-035 rst SHALL override abort and start, and asserting rst mid-frame SHALL discard the frame without a frame_done pulse.

Structure
REQ-036 phase_e, stop_mode_e and the DATA_MAX default SHALL reside in shared package uart_pkg.
REQ-037 The modulo-OVS tick counter and its mid/end pulse generation SHALL be a sub-module named uart_bit_timer, parameterised by OVS.

Verification
REQ-038 Case 8N1, OVS=16, single start: frame_done SHALL occur 160 cycles after START entry, with 8 DATA bit_end pulses and bit_idx 0..7.
REQ-039 Case 8E1.5: frame_done SHALL occur at cycle 184, with PARITY for 16 cycles and STOP for 24 cycles with one mid_tick.
REQ-040 Case 5N2 then 9E2 back-to-back, start held high: the second START SHALL begin the cycle after frame_done, with lengths 128 and 208.
REQ-041 Case cfg_data_bits changed from 8 to 5 at DATA bit 3: the frame SHALL still complete 8 data bits.
REQ-042 Case abort at DATA bit 4, tick 7: next cycle SHALL be IDLE with busy=0 and no frame_done; abort and start together SHALL stay IDLE.
REQ-043 Case rst mid-STOP, then cfg_data_bits=12 and cfg_stop_mode=11: the frame SHALL clamp to 9 data bits and 1 stop bit, with frame_done at cycle 176 without parity.
